// File: rtl/traffic_pkg.sv
// Shared channel state encodings, default timing constants and a saturating
// increment helper for the traffic sensor conditioner.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONFIRM = 3'd1,
        ST_PRESENT = 3'd2,
        ST_HOLD    = 3'd3,
        ST_FAULT   = 3'd4
    } chan_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 3;
    localparam int HOLD_CYCLES_DEF     = 4;
    localparam int STUCK_CYCLES_DEF    = 200;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sensor_channel.sv
// One loop-detector channel: 2-flop synchronizer, debounce/hold FSM and a
// saturating arrival counter. Stuck-sensor detection is built only when
// SENSOR_FAULT_EN is defined.
module sensor_channel
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw,
    output logic       s,
    output logic [7:0] cnt,
    output logic       fault
);

    localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W  = $clog2(MAX_DH + 1);
    localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || STUCK_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_check
        $error("sensor_channel: invalid DEBOUNCE/HOLD/STUCK cycle parameters");
    end

    logic             sync1_q, sync2_q;
    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] ctr_q, ctr_d;
    logic [7:0]       arr_q, arr_d;
    logic             s_q, s_d;
    logic             hi;

`ifdef SENSOR_FAULT_EN
    localparam int STUCK_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [STUCK_W-1:0] STUCK_LIM = STUCK_W'(STUCK_CYCLES);
    localparam logic [STUCK_W-1:0] STUCK_DEB = STUCK_W'(DEBOUNCE_CYCLES);
    localparam logic [STUCK_W-1:0] STUCK_ONE = STUCK_W'(1);
    logic [STUCK_W-1:0] stuck_q, stuck_d;
    logic               fault_q, fault_d;
`endif

    assign hi = sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_IDLE;
            ctr_q   <= '0;
            arr_q   <= '0;
            s_q     <= 1'b0;
`ifdef SENSOR_FAULT_EN
            stuck_q <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            ctr_q   <= ctr_d;
            arr_q   <= arr_d;
            s_q     <= s_d;
`ifdef SENSOR_FAULT_EN
            stuck_q <= stuck_d;
            fault_q <= fault_d;
`endif
        end
    end

    // ctr_q is shared: debounce count in CONFIRM, hold count in HOLD, low-sample count in FAULT.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        arr_d   = arr_q;
`ifdef SENSOR_FAULT_EN
        stuck_d = stuck_q;
`endif
        case (state_q)
            ST_IDLE: begin
                ctr_d = '0;
                if (hi) begin
                    if (DEB_LIM == CNT_ONE) begin
                        state_d = ST_PRESENT;
                        arr_d   = sat_inc8(arr_q);
`ifdef SENSOR_FAULT_EN
                        stuck_d = STUCK_DEB;
`endif
                    end else begin
                        state_d = ST_CONFIRM;
                        ctr_d   = CNT_ONE;
                    end
                end
            end
            ST_CONFIRM: begin
                if (!hi) begin
                    state_d = ST_IDLE;
                    ctr_d   = '0;
                end else if (ctr_q + CNT_ONE == DEB_LIM) begin
                    state_d = ST_PRESENT;
                    ctr_d   = '0;
                    arr_d   = sat_inc8(arr_q);
`ifdef SENSOR_FAULT_EN
                    stuck_d = STUCK_DEB;
`endif
                end else begin
                    ctr_d = ctr_q + CNT_ONE;
                end
            end
            ST_PRESENT: begin
                if (!hi) begin
                    state_d = (HOLD_LIM == CNT_ONE) ? ST_IDLE : ST_HOLD;
                    ctr_d   = (HOLD_LIM == CNT_ONE) ? '0 : CNT_ONE;
`ifdef SENSOR_FAULT_EN
                    stuck_d = '0;
                end else if (stuck_q + STUCK_ONE == STUCK_LIM) begin
                    state_d = ST_FAULT;
                    ctr_d   = '0;
                    stuck_d = '0;
                end else begin
                    stuck_d = stuck_q + STUCK_ONE;
`endif
                end
            end
            ST_HOLD: begin
                if (hi) begin
                    state_d = ST_PRESENT;
                    ctr_d   = '0;
`ifdef SENSOR_FAULT_EN
                    stuck_d = STUCK_ONE;
`endif
                end else if (ctr_q + CNT_ONE == HOLD_LIM) begin
                    state_d = ST_IDLE;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + CNT_ONE;
                end
            end
`ifdef SENSOR_FAULT_EN
            // Leaving FAULT enters HOLD with a zero count so the full hold time follows.
            ST_FAULT: begin
                if (hi) begin
                    ctr_d = '0;
                end else if (ctr_q + CNT_ONE == DEB_LIM) begin
                    state_d = ST_HOLD;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + CNT_ONE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                ctr_d   = '0;
            end
        endcase
    end

    always_comb begin
        s_d = (state_d == ST_PRESENT) || (state_d == ST_HOLD) || (state_d == ST_FAULT);
`ifdef SENSOR_FAULT_EN
        fault_d = (state_d == ST_FAULT);
`endif
    end

    assign s   = s_q;
    assign cnt = arr_q;
`ifdef SENSOR_FAULT_EN
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the street A/B loop detectors into Sa/Sb for the light controller.
// Optional stuck-sensor detection is enabled with SENSOR_FAULT_EN.
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_a,
    input  logic       raw_b,
    output logic       Sa,
    output logic       Sb,
    output logic [7:0] cnt_a,
    output logic [7:0] cnt_b,
    output logic       fault_a,
    output logic       fault_b
);

    sensor_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_chan_a (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_a),
        .s     (Sa),
        .cnt   (cnt_a),
        .fault (fault_a)
    );

    sensor_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_chan_b (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_b),
        .s     (Sb),
        .cnt   (cnt_b),
        .fault (fault_b)
    );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner at default parameters
// (DEBOUNCE=3, HOLD=4, STUCK=200); fault scenarios when SENSOR_FAULT_EN is defined.
module tb_traffic_sensor_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       raw_a = 1'b0;
    logic       raw_b = 1'b0;
    logic       Sa, Sb, fault_a, fault_b;
    logic [7:0] cnt_a, cnt_b;

    int pass_cnt = 0;
    int total_cnt = 0;

    traffic_sensor_conditioner dut (
        .clk     (clk),
        .reset   (reset),
        .raw_a   (raw_a),
        .raw_b   (raw_b),
        .Sa      (Sa),
        .Sb      (Sb),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b),
        .fault_a (fault_a),
        .fault_b (fault_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        raw_a = 1'b0;
        raw_b = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        raw_a = 1'b1;
        raw_b = 1'b1;
        tick();
        tick();
        total_cnt++; if ({Sa, Sb} !== 2'b00) $display("FAIL reset_s got %b want 00", {Sa, Sb}); else pass_cnt++;
        total_cnt++; if (cnt_a !== 8'd0 || cnt_b !== 8'd0) $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt_a, cnt_b); else pass_cnt++;
        total_cnt++; if ({fault_a, fault_b} !== 2'b00) $display("FAIL reset_fault got %b want 00", {fault_a, fault_b}); else pass_cnt++;
        raw_a = 1'b0;
        raw_b = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_latency();
        logic exp;
        do_reset();
        raw_a = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            exp = (c >= 5);
            total_cnt++; if (Sa !== exp) $display("FAIL latency_sa c=%0d got %b want %b", c, Sa, exp); else pass_cnt++;
            total_cnt++; if (Sb !== 1'b0 || cnt_b !== 8'd0) $display("FAIL latency_b c=%0d got Sb=%b cnt_b=%0d want 0/0", c, Sb, cnt_b); else pass_cnt++;
            if (c == 5) begin
                total_cnt++; if (cnt_a !== 8'd1) $display("FAIL latency_cnt got %0d want 1", cnt_a); else pass_cnt++;
            end
        end
    endtask

    task automatic test_hold();
        logic exp;
        raw_a = 1'b0;
        for (int c = 1; c <= 3; c++) tick();
        raw_a = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            total_cnt++; if (Sa !== 1'b1) $display("FAIL short_drop_sa c=%0d got %b want 1", c, Sa); else pass_cnt++;
        end
        total_cnt++; if (cnt_a !== 8'd1) $display("FAIL short_drop_cnt got %0d want 1", cnt_a); else pass_cnt++;
        raw_a = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp = (c < 6);
            total_cnt++; if (Sa !== exp) $display("FAIL hold_fall c=%0d got %b want %b", c, Sa, exp); else pass_cnt++;
        end
        total_cnt++; if (cnt_a !== 8'd1) $display("FAIL hold_cnt got %0d want 1", cnt_a); else pass_cnt++;
    endtask

    task automatic test_glitch();
        do_reset();
        raw_b = 1'b1;
        tick();
        tick();
        raw_b = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            total_cnt++; if (Sb !== 1'b0) $display("FAIL glitch_sb c=%0d got %b want 0", c, Sb); else pass_cnt++;
        end
        total_cnt++; if (cnt_b !== 8'd0) $display("FAIL glitch_cnt got %0d want 0", cnt_b); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic exp;
        do_reset();
        raw_a = 1'b1;
        raw_b = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp = (c >= 5);
            total_cnt++; if ({Sa, Sb} !== {exp, exp}) $display("FAIL simul_s c=%0d got %b want %b%b", c, {Sa, Sb}, exp, exp); else pass_cnt++;
        end
        total_cnt++; if (cnt_a !== 8'd1 || cnt_b !== 8'd1) $display("FAIL simul_cnt got %0d/%0d want 1/1", cnt_a, cnt_b); else pass_cnt++;
        raw_a = 1'b0;
        raw_b = 1'b0;
        for (int c = 1; c <= 10; c++) tick();
    endtask

    task automatic test_saturation();
        logic [7:0] exp;
        do_reset();
        for (int i = 1; i <= 290; i++) begin
            raw_a = 1'b1;
            raw_b = 1'b1;
            for (int c = 0; c < 4; c++) tick();
            raw_a = 1'b0;
            raw_b = 1'b0;
            for (int c = 0; c < 8; c++) tick();
            exp = (i > 255) ? 8'd255 : 8'(i);
            total_cnt++; if (cnt_a !== exp || cnt_b !== exp) $display("FAIL sat_cnt arrival=%0d got %0d/%0d want %0d", i, cnt_a, cnt_b, exp); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        raw_a = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        reset = 1'b1;
        tick();
        total_cnt++; if (Sa !== 1'b0 || cnt_a !== 8'd0) $display("FAIL rst_confirm got Sa=%b cnt=%0d want 0/0", Sa, cnt_a); else pass_cnt++;
        reset = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            total_cnt++; if (Sa !== (c == 5)) $display("FAIL rst_relatency c=%0d got %b want %b", c, Sa, (c == 5)); else pass_cnt++;
        end
        total_cnt++; if (cnt_a !== 8'd1) $display("FAIL rst_relatency_cnt got %0d want 1", cnt_a); else pass_cnt++;
        raw_a = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        reset = 1'b1;
        tick();
        total_cnt++; if (Sa !== 1'b0 || cnt_a !== 8'd0) $display("FAIL rst_hold got Sa=%b cnt=%0d want 0/0", Sa, cnt_a); else pass_cnt++;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        total_cnt++; if (Sa !== 1'b0) $display("FAIL rst_hold_after got %b want 0", Sa); else pass_cnt++;
    endtask

`ifdef SENSOR_FAULT_EN
    task automatic test_fault();
        do_reset();
        raw_a = 1'b1;
        for (int c = 1; c <= 250; c++) begin
            tick();
            if (c == 201) begin
                total_cnt++; if (fault_a !== 1'b0) $display("FAIL fault_early got %b want 0", fault_a); else pass_cnt++;
            end
            if (c == 202) begin
                total_cnt++; if (fault_a !== 1'b1 || Sa !== 1'b1) $display("FAIL fault_set got fault=%b Sa=%b want 1/1", fault_a, Sa); else pass_cnt++;
            end
        end
        raw_a = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            total_cnt++; if (fault_a !== (c < 5)) $display("FAIL fault_clear c=%0d got %b want %b", c, fault_a, (c < 5)); else pass_cnt++;
            total_cnt++; if (Sa !== (c < 9)) $display("FAIL fault_sa c=%0d got %b want %b", c, Sa, (c < 9)); else pass_cnt++;
        end
        raw_a = 1'b1;
        for (int c = 0; c < 205; c++) tick();
        total_cnt++; if (fault_a !== 1'b1) $display("FAIL fault_reenter got %b want 1", fault_a); else pass_cnt++;
        reset = 1'b1;
        tick();
        total_cnt++; if ({Sa, fault_a, Sb, fault_b} !== 4'b0000 || cnt_a !== 8'd0) $display("FAIL fault_reset got %b cnt=%0d want 0000/0", {Sa, fault_a, Sb, fault_b}, cnt_a); else pass_cnt++;
        reset = 1'b0;
        raw_a = 1'b0;
    endtask
`else
    task automatic test_no_fault();
        do_reset();
        raw_a = 1'b1;
        for (int c = 1; c <= 250; c++) begin
            tick();
            if (c == 202 || c == 250) begin
                total_cnt++; if (Sa !== 1'b1) $display("FAIL stay_present c=%0d got %b want 1", c, Sa); else pass_cnt++;
                total_cnt++; if ({fault_a, fault_b} !== 2'b00) $display("FAIL no_fault c=%0d got %b want 00", c, {fault_a, fault_b}); else pass_cnt++;
            end
        end
        raw_a = 1'b0;
        for (int c = 0; c < 10; c++) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_hold();
        test_glitch();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
`ifdef SENSOR_FAULT_EN
        test_fault();
`else
        test_no_fault();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_conditioner.md
TRAFFIC_SENSOR_CONDITIONER -- requirements
Module: traffic_sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 3: consecutive high synchronized samples needed to confirm a car.
REQ-002 Parameter HOLD_CYCLES, default 4: cycles the presence output is held after the sensor drops.
REQ-003 Parameter STUCK_CYCLES, default 200: continuous-high cycles that declare a stuck sensor (fault build only).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 raw_a, raw_b  in  1 each  asynchronous loop-detector inputs for street A and street B.
REQ-008 Sa, Sb  out  1 each  conditioned car-present flags; these drive the traffic light controller's Sa/Sb inputs directly.
REQ-009 cnt_a, cnt_b  out  8 each  saturating arrival counters.
REQ-010 fault_a, fault_b  out  1 each  stuck-sensor flags; tied 0 when SENSOR_FAULT_EN is undefined.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each channel SHALL run an independent FSM: IDLE, CONFIRM, PRESENT, HOLD, plus FAULT when SENSOR_FAULT_EN is defined.
REQ-013 IDLE -> CONFIRM on synchronized high; the debounce counter loads 1.
REQ-014 CONFIRM: synchronized high increments the counter; on reaching DEBOUNCE_CYCLES -> PRESENT. Synchronized low -> IDLE, counter cleared.
REQ-015 S SHALL be 1 in PRESENT, HOLD and FAULT, and 0 in IDLE and CONFIRM. It is registered.
REQ-016 Latency from a sustained raw rise to S=1 SHALL be exactly 2+DEBOUNCE_CYCLES clocks; a pulse shorter than DEBOUNCE_CYCLES synchronized samples SHALL never assert S.
REQ-017 PRESENT -> HOLD on synchronized low; the hold counter loads 1.
REQ-018 HOLD: synchronized high -> PRESENT immediately, with no re-debounce and no new arrival count. Otherwise the counter increments; on reaching HOLD_CYCLES -> IDLE, S=0.
REQ-019 Each CONFIRM -> PRESENT transition SHALL increment cnt by 1, saturating at 255 with no wrap.
REQ-020 Channels SHALL be fully independent; simultaneous events on A and B are processed in the same cycle with no priority.
REQ-021 Counter widths SHALL be ceil(log2(max+1)) of the largest applicable parameter; no overflow is possible within a state.

Reset
REQ-022 Reset SHALL force: synchronizers 0, FSMs IDLE, all internal counters 0, Sa=Sb=0, cnt_a=cnt_b=0, fault_a=fault_b=0.
REQ-023 Reset asserted mid-CONFIRM, mid-HOLD or in FAULT SHALL take effect at the next edge, overriding all transitions.
REQ-024 After reset release, the first S assertion SHALL still require the full 2+DEBOUNCE_CYCLES latency.

Configuration
REQ-025 Macro SENSOR_FAULT_EN defined: the PRESENT state counts continuous synchronized-high cycles (the count includes the debounce cycles); on reaching STUCK_CYCLES -> FAULT.
REQ-026 In FAULT, fault=1 and S=1 (fail-safe, so the street is still served). FAULT exits to HOLD only after DEBOUNCE_CYCLES consecutive synchronized-low samples.
REQ-027 Macro undefined: no stuck counter or FAULT state is built, fault outputs are constant 0, and a channel stays in PRESENT indefinitely while the sensor is high.

Structure
REQ-028 The shared package traffic_pkg SHALL hold the channel state encodings (IDLE=0, CONFIRM=1, PRESENT=2, HOLD=3, FAULT=4) and the default parameter constants.
REQ-029 One sub-module, sensor_channel (synchronizer + FSM + counters), SHALL be instantiated twice; the top level is wiring only.

Verification (defaults DEBOUNCE=3, HOLD=4, STUCK=200)
REQ-030 Reset, then raw_a held 1 from cycle 0 -> Sa=1 at cycle 5, cnt_a=1; Sb=0, cnt_b=0 throughout.
REQ-031 Glitches: raw_b high for 2 cycles, then low -> Sb stays 0, cnt_b=0.
REQ-032 raw_a low for 3 cycles inside PRESENT -> Sa stays 1 and cnt_a is unchanged. Low for 10 cycles -> Sa falls exactly 2+4 cycles after the raw fall.
REQ-033 Both raws rise on the same edge -> Sa and Sb assert on the same cycle, and both counters increment.
REQ-034 30 separated arrivals per channel with the cnt preloaded via 260 arrivals -> cnt saturates at 255 and never reads 0.
REQ-035 SENSOR_FAULT_EN: raw_a held 1 for 250 cycles -> fault_a=1 at cycle 202 with Sa=1; then raw_a low -> fault_a clears 2+3 cycles later, and Sa falls 4 cycles after that. Reset asserted during FAULT -> all outputs 0 at the next edge.
